// File: rtl/find_set_pkg.sv
// rtl/find_set_pkg.sv - shared types for the find_set_iterator slice
package find_set_pkg;

    typedef enum logic {
        FS_DIR_MSB_FIRST = 1'b0,
        FS_DIR_LSB_FIRST = 1'b1
    } fs_dir_t;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_SCAN = 1'b1
    } fs_iter_state_t;

endpackage

// File: rtl/find_set_prio.sv
// rtl/find_set_prio.sv - combinational priority encoder, highest or lowest set bit
module find_set_prio
    import find_set_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIR   = 0,
    localparam int IW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IW-1:0]    index,
    output logic             any
);

    // Later loop iterations overwrite earlier ones, so the scan runs toward the winning end.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (DIR == int'(FS_DIR_MSB_FIRST)) begin
                if (mask[i]) index = IW'(i);
            end else begin
                if (mask[WIDTH-1-i]) index = IW'(WIDTH - 1 - i);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/find_set_iterator.sv
// rtl/find_set_iterator.sv - streaming set-bit enumerator; FIND_SET_ITERATOR_COUNT_EN adds o_count/o_remaining
module find_set_iterator
    import find_set_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIR   = 0,
    localparam int IW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IW-1:0]    o_index,
    output logic             o_last,
    output logic             o_empty
`ifdef FIND_SET_ITERATOR_COUNT_EN
    ,
    output logic [IW:0]      o_count,
    output logic [IW:0]      o_remaining
`endif
);

    fs_iter_state_t   state_q, state_d;
    logic [WIDTH-1:0] mask_q;
    logic             empty_q;
    logic [IW-1:0]    prio_index;
    logic             prio_any;
    logic             one_hot;
    logic             accept;
    logic             beat_done;

    find_set_prio #(
        .WIDTH (WIDTH),
        .DIR   (DIR)
    ) u_prio (
        .mask  (mask_q),
        .index (prio_index),
        .any   (prio_any)
    );

    assign one_hot   = prio_any && ((mask_q & (mask_q - WIDTH'(1))) == '0);
    assign accept    = i_valid && o_ready;
    assign beat_done = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= FS_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_index = '0;
        o_last  = 1'b0;
        o_empty = 1'b0;
        case (state_q)
            FS_IDLE: begin
                o_ready = i_rst_n;
                if (i_valid && i_rst_n) state_d = FS_SCAN;
            end
            FS_SCAN: begin
                o_valid = 1'b1;
                o_index = prio_index;
                o_last  = one_hot || empty_q;
                o_empty = empty_q;
                if (i_ready && o_last) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // An empty vector leaves mask at zero, so clearing bit 0 on its single beat is harmless.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mask_q  <= '0;
            empty_q <= 1'b0;
        end else if (accept) begin
            mask_q  <= i_data;
            empty_q <= (i_data == '0);
        end else if (beat_done) begin
            mask_q[o_index] <= 1'b0;
            if (o_last) empty_q <= 1'b0;
        end
    end

`ifdef FIND_SET_ITERATOR_COUNT_EN
    logic [IW:0] count_q;
    logic [IW:0] pop_in;
    logic [IW:0] pop_mask;

    always_comb begin
        pop_in   = '0;
        pop_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_in   = pop_in + (IW+1)'(i_data[i]);
            pop_mask = pop_mask + (IW+1)'(mask_q[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                  count_q <= '0;
        else if (accept)               count_q <= pop_in;
        else if (beat_done && o_last)  count_q <= '0;
    end

    // Mask is zero whenever the block is idle, so remaining needs no state qualifier.
    assign o_count     = count_q;
    assign o_remaining = pop_mask;
`endif

endmodule
